// File: rtl/frame_buf_if.sv
// Bundles the write stream, read stream, status and RAM port signals of frame_buf_ctrl.
// slave is the controller's view; master is the parent/RAM-side view.
interface frame_buf_if #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 128
);
    localparam int unsigned DW = $clog2(D);

    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_last;
    logic          wr_abort;
    logic          wr_ready;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          rd_last;
    logic          rd_ready;
    logic [DW:0]   frame_count;
    logic          ovf_err;
    logic          mem_we;
    logic [DW-1:0] mem_waddr;
    logic [W:0]    mem_wdata;
    logic [DW-1:0] mem_raddr;
    logic [W:0]    mem_rdata;

    modport slave (
        input  wr_valid, wr_data, wr_last, wr_abort, rd_ready, mem_rdata,
        output wr_ready, rd_valid, rd_data, rd_last, frame_count, ovf_err,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output wr_valid, wr_data, wr_last, wr_abort, rd_ready, mem_rdata,
        input  wr_ready, rd_valid, rd_data, rd_last, frame_count, ovf_err,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Packet FIFO controller over an external two-port RAM: speculative writes with
// commit/abort, and a 2-entry prefetch buffer hiding the 1-cycle RAM read latency.
module frame_buf_ctrl #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 128
) (
    input  logic        clk,
    input  logic        rst,
    frame_buf_if.slave  bus
);
    localparam int unsigned DW = $clog2(D);
    localparam logic [DW:0] PTR_ONE   = (DW+1)'(1);
    localparam logic [DW:0] PTR_DEPTH = (DW+1)'(D);

    logic [DW:0] wptr, cptr, rptr;
    logic [DW:0] fcount;
    logic [W:0]  buf_q [2];
    logic [W:0]  buf_n [2];
    logic [1:0]  occ, occ_pop, occ_n, slots;
    logic        inflight;
    logic        ovf_q;

    logic wr_ready, oversize, accept, commit, pop, pop_last, issue;

    // Write-side qualification
    always_comb begin
        wr_ready = (wptr - rptr) != PTR_DEPTH;
        oversize = (wptr - cptr) == PTR_DEPTH;
        accept   = bus.wr_valid && wr_ready && !bus.wr_abort;
        commit   = accept && bus.wr_last;
    end

    // Read issue counts a same-cycle pop as freeing a buffer slot
    always_comb begin
        pop      = (occ != 2'd0) && bus.rd_ready;
        pop_last = pop && buf_q[0][W];
        slots    = occ + 2'(inflight) - 2'(pop);
        issue    = (rptr != cptr) && (slots < 2'd2);
    end

    // Output buffer: shift on pop, then land the in-flight word behind the head
    always_comb begin
        buf_n   = buf_q;
        occ_pop = occ - 2'(pop);
        if (pop) begin
            buf_n[0] = buf_q[1];
        end
        if (inflight) begin
            buf_n[occ_pop[0]] = bus.mem_rdata;
        end
        occ_n = occ_pop + 2'(inflight);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            cptr     <= '0;
            rptr     <= '0;
            fcount   <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (bus.wr_abort || oversize) begin
                wptr <= cptr;
            end else if (accept) begin
                wptr <= wptr + PTR_ONE;
            end
            if (commit) begin
                cptr <= wptr + PTR_ONE;
            end
            if (issue) begin
                rptr <= rptr + PTR_ONE;
            end
            if (commit && !pop_last) begin
                fcount <= fcount + PTR_ONE;
            end else if (!commit && pop_last) begin
                fcount <= fcount - PTR_ONE;
            end
            buf_q    <= buf_n;
            occ      <= occ_n;
            inflight <= issue;
            ovf_q    <= oversize;
        end
    end

    assign bus.wr_ready    = wr_ready;
    assign bus.mem_we      = accept;
    assign bus.mem_waddr   = wptr[DW-1:0];
    assign bus.mem_wdata   = {bus.wr_last, bus.wr_data};
    assign bus.mem_raddr   = rptr[DW-1:0];
    assign bus.rd_valid    = (occ != 2'd0);
    assign bus.rd_data     = buf_q[0][W-1:0];
    assign bus.rd_last     = buf_q[0][W];
    assign bus.frame_count = fcount;
    assign bus.ovf_err     = ovf_q;
endmodule
